// File: rtl/lg_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control unit: opcode match
// patterns, ALU and immediate-select codes, FSM state codes and the
// instruction class enumeration.
package lg_ctrl_pkg;

    // Opcode match patterns (instr[31:21]), '?' bits are don't-care in casez
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_ADDI = 11'b1001000100?;
    localparam logic [10:0] OP_SUBI = 11'b1101000100?;
    localparam logic [10:0] OP_MOVZ = 11'b110100101??;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100???;
    localparam logic [10:0] OP_CBNZ = 11'b10110101???;
    localparam logic [10:0] OP_B    = 11'b000101?????;

    // ALU operation codes
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    // Immediate format select for the sign extender
    localparam logic [1:0] SGN_I  = 2'b00;
    localparam logic [1:0] SGN_D  = 2'b01;
    localparam logic [1:0] SGN_CB = 2'b10;
    localparam logic [1:0] SGN_B  = 2'b11;

    // FSM state codes (visible on state_o)
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    typedef enum logic [3:0] {
        CLS_R_AND, CLS_R_ORR, CLS_R_ADD, CLS_R_SUB,
        CLS_I_ADD, CLS_I_SUB, CLS_MOVZ,
        CLS_LDUR, CLS_STUR,
        CLS_CBZ, CLS_CBNZ, CLS_B,
        CLS_ILL
    } cls_e;

    // Classes whose second register operand comes from the Rt field
    function automatic logic uses_reg2loc(input cls_e c);
        return (c == CLS_STUR) || (c == CLS_CBZ) || (c == CLS_CBNZ);
    endfunction

endpackage

// File: rtl/lg_opcode_decode.sv
// Combinational opcode classifier: maps the IR opcode field to an
// instruction class. CBNZ is only recognised when ENABLE_CBNZ is set.
module lg_opcode_decode
    import lg_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 11,
    parameter bit          ENABLE_CBNZ = 1'b1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output cls_e                cls
);

    // Priority-free match: the LEGv8 patterns below do not overlap
    always_comb begin
        cls = CLS_ILL;
        casez (opcode)
            OP_AND:  cls = CLS_R_AND;
            OP_ORR:  cls = CLS_R_ORR;
            OP_ADD:  cls = CLS_R_ADD;
            OP_SUB:  cls = CLS_R_SUB;
            OP_ADDI: cls = CLS_I_ADD;
            OP_SUBI: cls = CLS_I_SUB;
            OP_MOVZ: cls = CLS_MOVZ;
            OP_LDUR: cls = CLS_LDUR;
            OP_STUR: cls = CLS_STUR;
            OP_CBZ:  cls = CLS_CBZ;
            OP_CBNZ: cls = ENABLE_CBNZ ? CLS_CBNZ : CLS_ILL;
            OP_B:    cls = CLS_B;
            default: cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle LEGv8 control unit. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB over a shared memory with a ready handshake and
// decodes per-state datapath controls from the state and latched class.
module mc_control
    import lg_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W        = 11,
    parameter int unsigned ALUOP_W         = 4,
    parameter bit          ENABLE_CBNZ     = 1'b1,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                reg2loc,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                is_movz,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          sign_op,
    output logic                illegal,
    output logic [2:0]          state_o
);

    logic [2:0] state_q, state_d;
    cls_e       cls_q, dec_cls;
    logic       illegal_q;

    logic       ex_alu_src, ex_movz;
    logic [3:0] ex_alu_op;
    logic [1:0] ex_sign_op;

    lg_opcode_decode #(
        .OPCODE_W    (OPCODE_W),
        .ENABLE_CBNZ (ENABLE_CBNZ)
    ) u_decode (
        .opcode (opcode),
        .cls    (dec_cls)
    );

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (dec_cls == CLS_ILL) state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                else                    state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_B, CLS_CBZ, CLS_CBNZ: state_d = S_FETCH;
                    CLS_LDUR, CLS_STUR:       state_d = S_MEM;
                    default:                  state_d = S_WB;
                endcase
            end
            S_MEM:    if (mem_ready) state_d = (cls_q == CLS_STUR) ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // State, latched class and sticky illegal flag
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cls_q     <= CLS_R_AND;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q <= dec_cls;
                if (dec_cls == CLS_ILL && TRAP_ON_ILLEGAL) illegal_q <= 1'b1;
            end
        end
    end

    // Per-class datapath controls, shown in EXEC and held through MEM/WB
    always_comb begin
        ex_alu_src = 1'b0;
        ex_alu_op  = ALU_AND;
        ex_sign_op = SGN_I;
        ex_movz    = 1'b0;
        case (cls_q)
            CLS_R_ORR: ex_alu_op = ALU_ORR;
            CLS_R_ADD: ex_alu_op = ALU_ADD;
            CLS_R_SUB: ex_alu_op = ALU_SUB;
            CLS_I_ADD: begin ex_alu_src = 1'b1; ex_alu_op = ALU_ADD; end
            CLS_I_SUB: begin ex_alu_src = 1'b1; ex_alu_op = ALU_SUB; end
            CLS_MOVZ: begin
                ex_alu_src = 1'b1;
                ex_alu_op  = ALU_PASSB;
                ex_movz    = 1'b1;
            end
            CLS_LDUR, CLS_STUR: begin
                ex_alu_src = 1'b1;
                ex_alu_op  = ALU_ADD;
                ex_sign_op = SGN_D;
            end
            CLS_CBZ, CLS_CBNZ: begin
                ex_alu_op  = ALU_PASSB;
                ex_sign_op = SGN_CB;
            end
            CLS_B:     ex_sign_op = SGN_B;
            default:   ;
        endcase
    end

    // Output decode from state (FETCH/EXEC also qualify on mem_ready/Zero)
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        is_movz    = 1'b0;
        alu_op     = '0;
        sign_op    = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            // cls_q is not yet loaded here, so use the live decode
            S_DECODE: reg2loc = uses_reg2loc(dec_cls);
            S_EXEC: begin
                alu_src = ex_alu_src;
                alu_op  = ALUOP_W'(ex_alu_op);
                sign_op = ex_sign_op;
                reg2loc = uses_reg2loc(cls_q);
                is_movz = ex_movz;
                case (cls_q)
                    CLS_B:    begin pc_write = 1'b1;  pc_src = 1'b1; end
                    CLS_CBZ:  begin pc_write = Zero;  pc_src = 1'b1; end
                    CLS_CBNZ: begin pc_write = ~Zero; pc_src = 1'b1; end
                    default:  ;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = (cls_q == CLS_STUR);
                alu_src = ex_alu_src;
                alu_op  = ALUOP_W'(ex_alu_op);
                sign_op = ex_sign_op;
                reg2loc = uses_reg2loc(cls_q);
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == CLS_LDUR);
                alu_src    = ex_alu_src;
                alu_op     = ALUOP_W'(ex_alu_op);
                sign_op    = ex_sign_op;
                reg2loc    = uses_reg2loc(cls_q);
                is_movz    = ex_movz;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control. Three instances cover the parameter corners:
// dut0 defaults, dut1 ENABLE_CBNZ=0, dut2 TRAP_ON_ILLEGAL=0. A table of
// LEGv8 instruction kinds drives an expected per-cycle output trace.
module tb_mc_control;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
        logic       reg2loc, alu_src, mem_to_reg, reg_write, is_movz;
        logic [3:0] alu_op;
        logic [1:0] sign_op;
        logic       illegal;
    } vec_t;

    localparam int K_WB = 0, K_LD = 1, K_ST = 2, K_B = 3, K_CBZ = 4, K_CBNZ = 5;

    typedef struct {
        logic [10:0] mask;
        logic [10:0] val;
        int          kind;
        logic        asrc;
        logic [3:0]  aop;
        logic [1:0]  sop;
        logic        r2l;
        logic        mz;
    } ent_t;

    ent_t tbl [12];

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [10:0] op_a   [3];
    logic        zero_a [3];
    logic        rdy_a  [3];
    vec_t        obs    [3];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
        logic       reg2loc, alu_src, mem_to_reg, reg_write, is_movz, illegal;
        logic [3:0] alu_op;
        logic [1:0] sign_op;
        logic [2:0] state_o;

        mc_control #(
            .ENABLE_CBNZ     (g != 1),
            .TRAP_ON_ILLEGAL (g != 2)
        ) u_dut (
            .CLK        (CLK),
            .Reset      (Reset),
            .opcode     (op_a[g]),
            .Zero       (zero_a[g]),
            .mem_ready  (rdy_a[g]),
            .mem_req    (mem_req),
            .mem_we     (mem_we),
            .i_or_d     (i_or_d),
            .ir_write   (ir_write),
            .pc_write   (pc_write),
            .pc_src     (pc_src),
            .reg2loc    (reg2loc),
            .alu_src    (alu_src),
            .mem_to_reg (mem_to_reg),
            .reg_write  (reg_write),
            .is_movz    (is_movz),
            .alu_op     (alu_op),
            .sign_op    (sign_op),
            .illegal    (illegal),
            .state_o    (state_o)
        );

        assign obs[g] = {state_o, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                         reg2loc, alu_src, mem_to_reg, reg_write, is_movz, alu_op,
                         sign_op, illegal};
    end

    function automatic int classify(input logic [10:0] op, input bit cbnz_en);
        for (int i = 0; i < 12; i++)
            if ((op & tbl[i].mask) == tbl[i].val && (tbl[i].kind != K_CBNZ || cbnz_en))
                return i;
        return -1;
    endfunction

    // Expected outputs for phase ph (IDLE=0 .. TRAP=6) of instruction entry c
    function automatic vec_t expect_vec(input int ph, input int c, input bit rdy,
                                        input bit z);
        vec_t e;
        e = '0;
        e.st = 3'(ph);
        if (ph == 1) begin
            e.mem_req  = 1'b1;
            e.ir_write = rdy;
            e.pc_write = rdy;
        end else if (ph == 6) begin
            e.illegal = 1'b1;
        end else if (c >= 0 && ph == 2) begin
            e.reg2loc = tbl[c].r2l;
        end else if (c >= 0 && ph >= 3 && ph <= 5) begin
            e.alu_src = tbl[c].asrc;
            e.alu_op  = tbl[c].aop;
            e.sign_op = tbl[c].sop;
            e.reg2loc = tbl[c].r2l;
            if (ph != 4) e.is_movz = tbl[c].mz;
            if (ph == 3) begin
                if (tbl[c].kind == K_B)    begin e.pc_write = 1'b1; e.pc_src = 1'b1; end
                if (tbl[c].kind == K_CBZ)  begin e.pc_write = z;    e.pc_src = 1'b1; end
                if (tbl[c].kind == K_CBNZ) begin e.pc_write = !z;   e.pc_src = 1'b1; end
            end
            if (ph == 4) begin
                e.mem_req = 1'b1;
                e.i_or_d  = 1'b1;
                e.mem_we  = (tbl[c].kind == K_ST);
            end
            if (ph == 5) begin
                e.reg_write  = 1'b1;
                e.mem_to_reg = (tbl[c].kind == K_LD);
            end
        end
        return e;
    endfunction

    task automatic chk(input int k, input vec_t e, input string tag);
        checks++;
        assert (obs[k] === e) else begin
            errors++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs[k], e);
        end
    endtask

    // Called at a negedge: drive ready, check, advance one cycle
    task automatic cyc(input int k, input int ph, input int c, input bit rdy, input bit z,
                       input string tag);
        rdy_a[k] = rdy;
        #1;
        chk(k, expect_vec(ph, c, rdy, z), tag);
        @(negedge CLK);
    endtask

    // Async reset mid-cycle; returns at a negedge with every instance in FETCH
    task automatic do_reset();
        for (int k = 0; k < 3; k++) rdy_a[k] = 1'b0;
        #2 Reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) chk(k, '0, "reset_async");
        @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) chk(k, '0, "reset_idle");
        @(negedge CLK);
    endtask

    // One whole instruction on instance k: fw/mw = not-ready cycles in FETCH/MEM
    task automatic run_instr(input int k, input logic [10:0] op, input int fw, input int mw,
                             input bit z);
        int c;
        int kd;
        c = classify(op, k != 1);
        op_a[k]   = op;
        zero_a[k] = z;
        for (int i = 0; i <= fw; i++) cyc(k, 1, c, i == fw, z, "fetch");
        cyc(k, 2, c, 1'($urandom), z, "decode");
        if (c < 0) begin
            if (k != 2) for (int i = 0; i < 10; i++) cyc(k, 6, c, 1'($urandom), z, "trap");
            return;
        end
        kd = tbl[c].kind;
        cyc(k, 3, c, 1'($urandom), z, "exec");
        if (kd == K_LD || kd == K_ST)
            for (int i = 0; i <= mw; i++) cyc(k, 4, c, i == mw, z, "mem");
        if (kd == K_WB || kd == K_LD) cyc(k, 5, c, 1'($urandom), z, "wb");
    endtask

    function automatic logic [10:0] rand_op(input int idx);
        return tbl[idx].val | (11'($urandom) & ~tbl[idx].mask);
    endfunction

    initial begin
        int idx;
        logic [10:0] op;
        tbl[0]  = '{11'h7FF, 11'b10001010000, K_WB,   1'b0, 4'b0000, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{11'h7FF, 11'b10101010000, K_WB,   1'b0, 4'b0001, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{11'h7FF, 11'b10001011000, K_WB,   1'b0, 4'b0010, 2'b00, 1'b0, 1'b0};
        tbl[3]  = '{11'h7FF, 11'b11001011000, K_WB,   1'b0, 4'b0110, 2'b00, 1'b0, 1'b0};
        tbl[4]  = '{11'h7FE, 11'b10010001000, K_WB,   1'b1, 4'b0010, 2'b00, 1'b0, 1'b0};
        tbl[5]  = '{11'h7FE, 11'b11010001000, K_WB,   1'b1, 4'b0110, 2'b00, 1'b0, 1'b0};
        tbl[6]  = '{11'h7FC, 11'b11010010100, K_WB,   1'b1, 4'b0111, 2'b00, 1'b0, 1'b1};
        tbl[7]  = '{11'h7FF, 11'b11111000010, K_LD,   1'b1, 4'b0010, 2'b01, 1'b0, 1'b0};
        tbl[8]  = '{11'h7FF, 11'b11111000000, K_ST,   1'b1, 4'b0010, 2'b01, 1'b1, 1'b0};
        tbl[9]  = '{11'h7F8, 11'b10110100000, K_CBZ,  1'b0, 4'b0111, 2'b10, 1'b1, 1'b0};
        tbl[10] = '{11'h7F8, 11'b10110101000, K_CBNZ, 1'b0, 4'b0111, 2'b10, 1'b1, 1'b0};
        tbl[11] = '{11'h7E0, 11'b00010100000, K_B,    1'b0, 4'b0000, 2'b11, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            op_a[k] = '0; zero_a[k] = 1'b0; rdy_a[k] = 1'b0;
        end

        @(negedge CLK);
        do_reset();

        // Directed: ADD, LDUR with MEM stalls, STUR then back-to-back ADD
        run_instr(0, 11'b10001011000, 0, 0, 1'b0);
        run_instr(0, 11'b11111000010, 0, 2, 1'b0);
        run_instr(0, 11'b11111000000, 0, 0, 1'b0);
        run_instr(0, 11'b10001011000, 1, 0, 1'b1);
        // Conditional branches with Zero=1
        run_instr(0, 11'b10110100000, 0, 0, 1'b1);
        run_instr(0, 11'b10110101000, 0, 0, 1'b1);

        // Reset asserted in the middle of an ADD's EXEC cycle
        op_a[0] = 11'b10001011000;
        zero_a[0] = 1'b0;
        cyc(0, 1, 2, 1'b1, 1'b0, "mx_fetch");
        cyc(0, 2, 2, 1'b0, 1'b0, "mx_decode");
        rdy_a[0] = 1'b0;
        #1 chk(0, expect_vec(3, 2, 1'b0, 1'b0), "mx_exec");
        do_reset();

        // CBNZ with the extension disabled traps
        run_instr(1, 11'b10110101000, 0, 0, 1'b1);
        do_reset();
        // All-zero opcode: trap on dut0, NOP on dut2
        run_instr(0, 11'b00000000000, 0, 0, 1'b0);
        run_instr(2, 11'b00000000000, 0, 0, 1'b0);
        run_instr(2, 11'b10001011000, 0, 0, 1'b0);
        do_reset();

        // Randomised streams
        for (int n = 0; n < 150; n++) begin
            idx = $urandom_range(0, 11);
            run_instr(0, rand_op(idx), $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom));
        end
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 11);
            if (tbl[idx].kind == K_CBNZ) idx = idx - 1;
            run_instr(1, rand_op(idx), $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom));
        end
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 11);
            op = ($urandom_range(0, 4) == 0) ? 11'b00000000000 : rand_op(idx);
            run_instr(2, op, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
